// File: rtl/width_conv_arbiter.sv
// ============================================================================
// Module   : width_conv_arbiter
// Brief    : Round-robin arbiter that shares one 8->16 byte-pair width
//            converter between N_REQ byte-stream requesters. Each grant
//            covers exactly two bytes so a converter word never mixes
//            sources; the converter's output word is tagged with its
//            source id.
// Config   : PAIR_TIMEOUT_EN (optional macro) enables the stall counter,
//            pad-byte injection in SECOND and the timeout drop in FIRST.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module width_conv_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         ID_W     = 2,
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 conv_valid_in,
  output logic [7:0]           conv_data_in,
  input  logic                 conv_valid_out,
  output logic                 out_valid,
  output logic [ID_W-1:0]      out_id,
  output logic                 busy,
  output logic                 pad_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic            conv_valid_q, conv_valid_d;
  logic [7:0]      conv_data_q, conv_data_d;
  logic            pad_err_q, pad_err_d;

  logic            pick_found_w;
  logic [ID_W-1:0] pick_idx_w;
  logic            accept_w;
  logic [7:0]      byte_w;

`ifdef PAIR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] stall_q, stall_d;
`else
  // TIMEOUT and PAD_BYTE only matter when the timeout feature is built in.
  logic unused_cfg;
  assign unused_cfg = ^{PAD_BYTE, TIMEOUT[0]};
`endif

  // Ready depends only on state and grant, never on req_valid.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q != S_IDLE) && (grant_q == ID_W'(i));
    end
  end

  // Select the granted requester's byte and detect the handshake.
  always_comb begin
    byte_w = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        byte_w = req_data[8*i +: 8];
      end
    end
  end

  assign accept_w = |(req_valid & req_ready);

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    pick_found_w = 1'b0;
    pick_idx_w   = '0;
    idx          = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!pick_found_w && req_valid[idx]) begin
        pick_found_w = 1'b1;
        pick_idx_w   = ID_W'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/FIRST/SECOND pair FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    out_id_d     = out_id_q;
    conv_valid_d = 1'b0;
    conv_data_d  = conv_data_q;
    pad_err_d    = 1'b0;
`ifdef PAIR_TIMEOUT_EN
    stall_d      = stall_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found_w) begin
          grant_d  = pick_idx_w;
          rr_ptr_d = ID_W'((int'(pick_idx_w) + 1) % N_REQ);
          state_d  = S_FIRST;
`ifdef PAIR_TIMEOUT_EN
          stall_d  = '0;
`endif
        end
      end
      S_FIRST: begin
        if (accept_w) begin
          conv_valid_d = 1'b1;
          conv_data_d  = byte_w;
          state_d      = S_SECOND;
`ifdef PAIR_TIMEOUT_EN
          stall_d      = '0;
        end else if (stall_q == C_TIMEOUT) begin
          // Nothing accepted yet, so abandon the grant silently.
          state_d      = S_IDLE;
        end else begin
          stall_d      = stall_q + 1'b1;
`endif
        end
      end
      S_SECOND: begin
        if (accept_w) begin
          conv_valid_d = 1'b1;
          conv_data_d  = byte_w;
          out_id_d     = grant_q;
          state_d      = S_IDLE;
`ifdef PAIR_TIMEOUT_EN
        end else if (stall_q == C_TIMEOUT) begin
          // Complete the half-written word with the pad byte so the
          // converter's phase stays aligned.
          conv_valid_d = 1'b1;
          conv_data_d  = PAD_BYTE;
          out_id_d     = grant_q;
          pad_err_d    = 1'b1;
          state_d      = S_IDLE;
        end else begin
          stall_d      = stall_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      out_id_q     <= '0;
      conv_valid_q <= 1'b0;
      conv_data_q  <= 8'h00;
      pad_err_q    <= 1'b0;
`ifdef PAIR_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      out_id_q     <= out_id_d;
      conv_valid_q <= conv_valid_d;
      conv_data_q  <= conv_data_d;
      pad_err_q    <= pad_err_d;
`ifdef PAIR_TIMEOUT_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign conv_valid_in = conv_valid_q;
  assign conv_data_in  = conv_data_q;
  assign out_valid     = conv_valid_out;
  assign out_id        = out_id_q;
  assign busy          = (state_q != S_IDLE);
  assign pad_err       = pad_err_q;

endmodule

`default_nettype wire

// File: tb/tb_width_conv_arbiter.sv
// ============================================================================
// Module   : tb_width_conv_arbiter
// Brief    : Self-checking bench for width_conv_arbiter with a byte-pair
//            converter model downstream. Build with PAIR_TIMEOUT_EN defined
//            to exercise the pad-injection path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_width_conv_arbiter;

  localparam int         N_REQ    = 4;
  localparam int         ID_W     = 2;
  localparam int         TIMEOUT  = 4;
  localparam logic [7:0] PAD_BYTE = 8'h00;
  localparam int         BUF      = 512;
  localparam int         OBS      = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_ready;
  logic                 conv_valid_in;
  logic [7:0]           conv_data_in;
  logic                 conv_valid_out;
  logic                 out_valid;
  logic [ID_W-1:0]      out_id;
  logic                 busy;
  logic                 pad_err;

  width_conv_arbiter #(
    .N_REQ    (N_REQ),
    .ID_W     (ID_W),
    .TIMEOUT  (TIMEOUT),
    .PAD_BYTE (PAD_BYTE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .conv_valid_in  (conv_valid_in),
    .conv_data_in   (conv_data_in),
    .conv_valid_out (conv_valid_out),
    .out_valid      (out_valid),
    .out_id         (out_id),
    .busy           (busy),
    .pad_err        (pad_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Downstream 8->16 converter: first byte high, second byte low, word one cycle later.
  logic        conv_phase;
  logic [7:0]  conv_hi;
  logic [15:0] conv_word;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_phase     <= 1'b0;
      conv_hi        <= 8'h00;
      conv_word      <= 16'h0000;
      conv_valid_out <= 1'b0;
    end else begin
      conv_valid_out <= 1'b0;
      if (conv_valid_in) begin
        if (!conv_phase) begin
          conv_hi    <= conv_data_in;
          conv_phase <= 1'b1;
        end else begin
          conv_word      <= {conv_hi, conv_data_in};
          conv_valid_out <= 1'b1;
          conv_phase     <= 1'b0;
        end
      end
    end
  end

  // Requester byte sources: initial writes txbuf/tail/base, driver owns head.
  logic [7:0]       txbuf [N_REQ][BUF];
  int               head  [N_REQ];
  int               tail  [N_REQ];
  int               base  [N_REQ];
  int               acc_cyc [N_REQ];
  logic [N_REQ-1:0] drv_en = '0;
  bit               rand_gaps = 1'b0;
  int               dcyc = 0;

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      head[i] = 0; tail[i] = 0; base[i] = 0; acc_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    dcyc = dcyc + 1;
    for (int i = 0; i < N_REQ; i++) begin
      logic v;
      v = drv_en[i] && (head[i] != tail[i]);
      // Random gaps only at pair boundaries, so a started pair always completes.
      if (v && rand_gaps && (((head[i] - base[i]) % 2) == 0) && ($urandom_range(3) == 0))
        v = 1'b0;
      req_valid[i]       = v;
      req_data[8*i +: 8] = v ? txbuf[i][head[i] % BUF] : 8'h00;
    end
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        head[i]    = head[i] + 1;
        acc_cyc[i] = dcyc;
      end
    end
  end

  // Output monitor: word capture, pulse counters and per-cycle invariants.
  logic [ID_W-1:0] obs_id   [OBS];
  logic [15:0]     obs_word [OBS];
  int   obs_wr = 0, obs_rd = 0;
  int   mcyc = 0, cvi_cnt = 0, pad_cnt = 0, pad_cyc = 0, inv_err = 0;
  logic pad_cvi = 1'b0;
  logic [7:0] pad_data = 8'h00;

  always @(negedge clk) begin
    mcyc = mcyc + 1;
    if (out_valid === 1'b1) begin
      obs_id[obs_wr % OBS]   = out_id;
      obs_word[obs_wr % OBS] = conv_word;
      obs_wr = obs_wr + 1;
    end
    if (conv_valid_in === 1'b1) cvi_cnt = cvi_cnt + 1;
    if (pad_err === 1'b1) begin
      pad_cnt  = pad_cnt + 1;
      pad_cyc  = mcyc;
      pad_cvi  = conv_valid_in;
      pad_data = conv_data_in;
    end
    if (!rst) begin
      if (!$onehot0(req_ready) || (busy === 1'b0 && req_ready !== '0) ||
          (out_valid !== conv_valid_out))
        inv_err = inv_err + 1;
`ifndef PAIR_TIMEOUT_EN
      if (pad_err !== 1'b0) inv_err = inv_err + 1;
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int i, input logic [7:0] b);
    txbuf[i][tail[i] % BUF] = b;
    tail[i] = tail[i] + 1;
  endtask

  task automatic do_reset();
    drv_en    = '0;
    rand_gaps = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      tail[i] = head[i];
      base[i] = head[i];
    end
    tick(2);
    rst    = 1'b0;
    obs_rd = obs_wr;
  endtask

  task automatic get_word(input string nm, output logic [ID_W-1:0] id, output logic [15:0] w);
    int t;
    t = 0;
    while (obs_wr == obs_rd && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (obs_wr == obs_rd) begin
      n_checks++;
      $display("FAIL %s: no converter word within %0d cycles", nm, t);
      id = '0;
      w  = 16'h0000;
    end else begin
      id = obs_id[obs_rd % OBS];
      w  = obs_word[obs_rd % OBS];
      obs_rd = obs_rd + 1;
    end
  endtask

  task automatic wait_accept(input string nm, input int i, input int h0);
    int t;
    t = 0;
    while (head[i] == h0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (head[i] == h0) begin
      n_checks++;
      $display("FAIL %s: byte never accepted from req%0d", nm, i);
    end
  endtask

  typedef struct {
    int          id;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_word;
    logic [1:0]  exp_id;
  } vec_t;

  initial begin
    vec_t            vecs [4];
    logic [ID_W-1:0] gid;
    logic [15:0]     gw;
    int              c0, h0, pc0, total;
    int              cnt [N_REQ];
    int              wc  [N_REQ];

    vecs[0] = '{0, 8'hA1, 8'hB2, 16'hA1B2, 2'd0};
    vecs[1] = '{2, 8'h3C, 8'h4D, 16'h3C4D, 2'd2};
    vecs[2] = '{3, 8'hFF, 8'h00, 16'hFF00, 2'd3};
    vecs[3] = '{1, 8'h11, 8'h22, 16'h1122, 2'd1};

    // Reset state while rst is held.
    tick(2);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_conv_valid_in", 32'(conv_valid_in), 0);
    check("rst_conv_data_in", 32'(conv_data_in), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pad_err", 32'(pad_err), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    tick(1);

    // Single-requester pairs from the vector table.
    foreach (vecs[v]) begin
      c0 = cvi_cnt;
      push(vecs[v].id, vecs[v].b0);
      push(vecs[v].id, vecs[v].b1);
      drv_en = N_REQ'(1 << vecs[v].id);
      get_word($sformatf("vec%0d", v), gid, gw);
      check($sformatf("vec%0d_word", v), 32'(gw), 32'(vecs[v].exp_word));
      check($sformatf("vec%0d_id", v), 32'(gid), 32'(vecs[v].exp_id));
      tick(2);
      check($sformatf("vec%0d_cvi_pulses", v), 32'(cvi_cnt - c0), 2);
    end

    // All four requesters continuously valid: two full round-robin rounds.
    do_reset();
    for (int i = 0; i < N_REQ; i++)
      for (int k = 0; k < 4; k++) push(i, 8'((i << 4) | k));
    drv_en = '1;
    for (int k = 0; k < 2 * N_REQ; k++) begin
      get_word($sformatf("rr%0d", k), gid, gw);
      check($sformatf("rr%0d_id", k), 32'(gid), 32'(k % N_REQ));
      check($sformatf("rr%0d_word", k), 32'(gw),
            32'({8'(((k % N_REQ) << 4) | (2 * (k / N_REQ))),
                 8'(((k % N_REQ) << 4) | (2 * (k / N_REQ) + 1))}));
    end

    // rr_ptr=2 after serving req1; req1 and req2 then compete in the same IDLE cycle.
    do_reset();
    push(1, 8'h09); push(1, 8'h0A);
    drv_en = 4'b0110;
    get_word("prio_setup", gid, gw);
    check("prio_setup_id", 32'(gid), 1);
    tick(2);
    push(1, 8'h21); push(1, 8'h22);
    push(2, 8'h31); push(2, 8'h32);
    get_word("prio_first", gid, gw);
    check("prio_first_id", 32'(gid), 2);
    check("prio_first_word", 32'(gw), 32'h3132);
    get_word("prio_next", gid, gw);
    check("prio_next_id", 32'(gid), 1);
    check("prio_next_word", 32'(gw), 32'h2122);

    // Reset while in SECOND after one byte, then a clean pair.
    do_reset();
    h0 = head[1];
    push(1, 8'h77);
    drv_en = 4'b0010;
    wait_accept("midrst", 1, h0);
    tick(1);
    check("midrst_busy_before", 32'(busy), 1);
    check("midrst_data_before", 32'(conv_data_in), 32'h77);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_conv_valid_in", 32'(conv_valid_in), 0);
    check("midrst_conv_data_in", 32'(conv_data_in), 0);
    check("midrst_out_id", 32'(out_id), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pad_err", 32'(pad_err), 0);
    @(negedge clk);
    rst = 1'b0;
    obs_rd = obs_wr;
    push(1, 8'h11); push(1, 8'h22);
    get_word("midrst_after", gid, gw);
    check("midrst_after_word", 32'(gw), 32'h1122);
    check("midrst_after_id", 32'(gid), 1);

    // req3 sends one byte and stalls in SECOND.
    do_reset();
    pc0 = pad_cnt;
    h0  = head[3];
    push(3, 8'h5A);
    drv_en = 4'b1000;
    wait_accept("stall", 3, h0);
`ifdef PAIR_TIMEOUT_EN
    begin
      int t;
      t = 0;
      while (pad_cnt == pc0 && t < 40) begin
        @(negedge clk);
        t++;
      end
    end
    // Accept edge, then TIMEOUT+1 cycles in SECOND, then the pulse is visible.
    check("pad_latency", 32'(pad_cyc - acc_cyc[3]), 32'(TIMEOUT + 2));
    check("pad_cvi", 32'(pad_cvi), 1);
    check("pad_data", 32'(pad_data), 32'(PAD_BYTE));
    get_word("pad_word", gid, gw);
    check("pad_word", 32'(gw), 32'h5A00);
    check("pad_id", 32'(gid), 3);
    tick(10);
    check("pad_pulses", 32'(pad_cnt - pc0), 1);
    check("pad_idle", 32'(busy), 0);
`else
    tick(30);
    check("stall_busy", 32'(busy), 1);
    check("stall_pad_pulses", 32'(pad_cnt - pc0), 0);
    check("stall_no_word", 32'(obs_wr - obs_rd), 0);
    push(3, 8'h66);
    get_word("stall_word", gid, gw);
    check("stall_word", 32'(gw), 32'h5A66);
    check("stall_id", 32'(gid), 3);
`endif

    // Randomised traffic: every word must be the next byte pair of its source.
    do_reset();
    total = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt[i] = 2 * $urandom_range(1, 6);
      wc[i]  = 0;
      for (int k = 0; k < cnt[i]; k++) push(i, 8'($urandom));
      total += cnt[i] / 2;
    end
    rand_gaps = 1'b1;
    drv_en    = '1;
    for (int k = 0; k < total; k++) begin
      logic [15:0] expw;
      get_word($sformatf("rnd%0d", k), gid, gw);
      if (int'(gid) < N_REQ && wc[gid] < cnt[gid] / 2) begin
        expw = {txbuf[gid][(base[gid] + 2 * wc[gid]) % BUF],
                txbuf[gid][(base[gid] + 2 * wc[gid] + 1) % BUF]};
        check($sformatf("rnd%0d_word_id%0d", k, gid), 32'(gw), 32'(expw));
        wc[gid]++;
      end else begin
        n_checks++;
        $display("FAIL rnd%0d_id: got %0d with no pair outstanding", k, gid);
      end
    end
    for (int i = 0; i < N_REQ; i++)
      check($sformatf("rnd_pairs_req%0d", i), 32'(wc[i]), 32'(cnt[i] / 2));

    tick(3);
    check("invariants", 32'(inv_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
